// File: rtl/cache_arbiter_l2.sv
// cache_arbiter_l2: grants one of the L1 I/D line requests at a time and forwards it to the L2
module cache_arbiter_l2 #(
    parameter int ROUND_ROBIN = 1,
    parameter int ADDR_W      = 16,
    parameter int LINE_W      = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic              i_resp,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [LINE_W-1:0] d_rdata,
    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_address,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic              l2_resp,
    input  logic [LINE_W-1:0] l2_rdata
);
    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
    state_t              r_state, w_next;
    logic                r_last_d, r_op_write;
    logic [ADDR_W-1:0]   r_addr;
    logic [LINE_W-1:0]   r_wdata;
    logic                w_grant_d, w_grant_i, w_serving, w_done;
    // arbitration, next state and output decode; responses are suppressed while reset is asserted
    always_comb begin
        w_grant_d  = (d_read | d_write) & (!i_read | (ROUND_ROBIN == 0) | !r_last_d);
        w_grant_i  = i_read & !w_grant_d;
        w_serving  = r_state != IDLE;
        w_done     = w_serving & l2_resp & !reset;
        w_next     = (r_state == IDLE) ? (w_grant_d ? SERVE_D : w_grant_i ? SERVE_I : IDLE)
                                       : (l2_resp ? IDLE : r_state);
        l2_read    = w_serving & !r_op_write;
        l2_write   = w_serving & r_op_write;
        l2_address = w_serving ? r_addr : '0;
        l2_wdata   = w_serving ? r_wdata : '0;
        i_resp     = w_done & (r_state == SERVE_I);
        d_resp     = w_done & (r_state == SERVE_D);
        i_rdata    = (w_done & (r_state == SERVE_I)) ? l2_rdata : '0;
        d_rdata    = (w_done & (r_state == SERVE_D)) ? l2_rdata : '0;
    end
    // state register, command latch on grant, and last-served tracking on completion
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_last_d   <= 1'b0;
            r_op_write <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && (w_grant_d || w_grant_i)) begin
                r_op_write <= w_grant_d & d_write;
                r_addr     <= w_grant_d ? d_address : i_address;
                r_wdata    <= (w_grant_d & d_write) ? d_wdata : '0;
            end
            if (w_serving && l2_resp)
                r_last_d <= r_state == SERVE_D;
        end
    end
endmodule

// File: tb/tb_cache_arbiter_l2.sv
// tb_cache_arbiter_l2: directed checks of the L2 arbiter, round-robin and fixed-priority builds
module tb_cache_arbiter_l2;
    logic          clk = 0, reset = 1;
    logic          i_read = 0, d_read = 0, d_write = 0, l2_resp = 0;
    logic [15:0]   i_address = 0, d_address = 0;
    logic [127:0]  d_wdata = 0, l2_rdata = 0;
    logic          i_resp, d_resp, l2_read, l2_write;
    logic [127:0]  i_rdata, d_rdata, l2_wdata;
    logic [15:0]   l2_address;
    logic          i_resp_0, d_resp_0, l2_read_0, l2_write_0;
    logic [127:0]  i_rdata_0, d_rdata_0, l2_wdata_0;
    logic [15:0]   l2_address_0;
    int            n_checks = 0, n_errors = 0;

    always #5 clk = ~clk;

    cache_arbiter_l2 #(.ROUND_ROBIN(1)) dut (
        .clk(clk), .reset(reset), .i_read(i_read), .i_address(i_address), .i_resp(i_resp),
        .i_rdata(i_rdata), .d_read(d_read), .d_write(d_write), .d_address(d_address),
        .d_wdata(d_wdata), .d_resp(d_resp), .d_rdata(d_rdata), .l2_read(l2_read),
        .l2_write(l2_write), .l2_address(l2_address), .l2_wdata(l2_wdata),
        .l2_resp(l2_resp), .l2_rdata(l2_rdata));

    cache_arbiter_l2 #(.ROUND_ROBIN(0)) dut0 (
        .clk(clk), .reset(reset), .i_read(i_read), .i_address(i_address), .i_resp(i_resp_0),
        .i_rdata(i_rdata_0), .d_read(d_read), .d_write(d_write), .d_address(d_address),
        .d_wdata(d_wdata), .d_resp(d_resp_0), .d_rdata(d_rdata_0), .l2_read(l2_read_0),
        .l2_write(l2_write_0), .l2_address(l2_address_0), .l2_wdata(l2_wdata_0),
        .l2_resp(l2_resp), .l2_rdata(l2_rdata));

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        step(); step();
        reset = 0;
        #1;
        chk("rst_l2_read", l2_read, 0);
        chk("rst_l2_write", l2_write, 0);
        chk("rst_l2_addr", l2_address, 0);
        chk("rst_l2_wdata", l2_wdata, 0);
        chk("rst_resp", {i_resp, d_resp}, 0);
        chk("rst_rdata", i_rdata | d_rdata, 0);

        // I-cache read
        step();
        i_read = 1; i_address = 16'h1230;
        #1 chk("t1_cycN_l2_read", l2_read, 0);
        step();
        #1 chk("t1_l2_read", l2_read, 1);
        chk("t1_l2_write", l2_write, 0);
        chk("t1_l2_addr", l2_address, 16'h1230);
        chk("t1_l2_wdata", l2_wdata, 0);
        chk("t1_no_resp_yet", i_resp, 0);
        l2_resp = 1; l2_rdata = {16{8'hA5}};
        #1 chk("t1_i_resp", i_resp, 1);
        chk("t1_i_rdata", i_rdata, {16{8'hA5}});
        chk("t1_d_resp", d_resp, 0);
        chk("t1_d_rdata", d_rdata, 0);
        step();
        l2_resp = 0; i_read = 0;
        #1 chk("t1_idle_l2_read", l2_read, 0);
        chk("t1_idle_i_resp", i_resp, 0);
        chk("t1_idle_i_rdata", i_rdata, 0);

        // l2_resp while idle is ignored
        l2_resp = 1;
        #1 chk("idle_resp", {i_resp, d_resp}, 0);
        step();
        l2_resp = 0;
        #1 chk("idle_stay", l2_read | l2_write, 0);

        // D-cache writeback, address change during service ignored
        d_write = 1; d_address = 16'h4560; d_wdata = {4{32'hDEADBEEF}};
        step();
        #1 chk("t2_l2_write", l2_write, 1);
        chk("t2_l2_read", l2_read, 0);
        chk("t2_l2_addr", l2_address, 16'h4560);
        chk("t2_l2_wdata", l2_wdata, {4{32'hDEADBEEF}});
        d_address = 16'h7770; d_wdata = 0;
        step();
        #1 chk("t5_addr_held", l2_address, 16'h4560);
        chk("t5_wdata_held", l2_wdata, {4{32'hDEADBEEF}});
        l2_resp = 1; l2_rdata = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
        #1 chk("t2_d_resp", d_resp, 1);
        chk("t2_d_rdata", d_rdata, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677);
        chk("t2_i_resp", i_resp, 0);
        chk("t2_i_rdata", i_rdata, 0);
        step();
        l2_resp = 0; d_write = 0;
        #1 chk("t2_write_drop", l2_write, 0);
        chk("t2_d_resp_drop", d_resp, 0);

        // D read with write data on the bus: forwarded wdata must be 0
        d_read = 1; d_address = 16'h0AB0; d_wdata = {4{32'h55AA55AA}};
        step();
        #1 chk("dr_l2_read", l2_read, 1);
        chk("dr_l2_wdata", l2_wdata, 0);
        l2_resp = 1;
        step();
        l2_resp = 0; d_read = 0;

        // simultaneous read+write: write wins
        d_read = 1; d_write = 1; d_address = 16'h0CC0; d_wdata = {4{32'h12345678}};
        step();
        #1 chk("rw_l2_write", l2_write, 1);
        chk("rw_l2_read", l2_read, 0);
        l2_resp = 1;
        step();
        l2_resp = 0; d_read = 0; d_write = 0;

        // both ports requesting from reset: RR alternates D,I,D,I; fixed priority always D
        reset = 1;
        i_read = 1; i_address = 16'h1111; d_read = 1; d_address = 16'h2222; d_wdata = 0;
        step();
        reset = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            #1 chk("rr_addr", l2_address, (k % 2 == 0) ? 16'h2222 : 16'h1111);
            chk("fp_addr", l2_address_0, 16'h2222);
            l2_resp = 1; l2_rdata = 128'(k + 1);
            #1 chk("rr_d_resp", d_resp, (k % 2 == 0) ? 1'b1 : 1'b0);
            chk("rr_i_resp", i_resp, (k % 2 == 0) ? 1'b0 : 1'b1);
            chk("fp_d_resp", d_resp_0, 1);
            chk("fp_i_resp", i_resp_0, 0);
            chk("fp_d_rdata", d_rdata_0, 128'(k + 1));
            step();
            l2_resp = 0;
        end
        i_read = 0; d_read = 0;
        step();

        // reset during SERVE_I drops the transaction
        i_read = 1; i_address = 16'h3330;
        step();
        #1 chk("t6_l2_read", l2_read, 1);
        reset = 1;
        step();
        reset = 0; i_read = 0;
        #1 chk("t6_l2_read_off", l2_read, 0);
        chk("t6_l2_addr", l2_address, 0);
        chk("t6_no_resp", {i_resp, d_resp}, 0);
        l2_resp = 1;
        #1 chk("t6_idle_after", i_resp, 0);
        step();
        l2_resp = 0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
